// File: rtl/pcie_lcrc_stream.sv
// -----------------------------------------------------------------------------
// pcie_lcrc_stream
// Streaming LCRC (CRC-32, reflected, poly 0x04C11DB7) generator/checker for
// the PCIe data link layer. A packet (sequence-number prefix + TLP bytes)
// arrives as valid/ready beats of DATA_BYTES bytes. One registered result
// (CRC, length, pass/fail) is produced per packet on a valid/ready result port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_sop/in_eop       first/last beat of packet
//   in_data             byte k = in_data[8k+7:8k], byte 0 first on the wire
//   in_nbytes           valid low bytes on the eop beat (1..DATA_BYTES)
//   check_en, crc_exp   compare request and received LCRC, sampled on eop
//   res_valid/res_ready result handshake
//   res_crc             final LCRC, res_crc[7:0] transmitted first
//   res_ok              CRC match (1 when check_en was 0)
//   res_len             saturating packet byte count
//   proto_err           one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module pcie_lcrc_stream #(
  parameter int          DATA_BYTES = 4,
  parameter int          LEN_W      = 16,
  parameter logic [31:0] SEED       = 32'hFFFF_FFFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sop,
  input  logic                            in_eop,
  input  logic [8*DATA_BYTES-1:0]         in_data,
  input  logic [$clog2(DATA_BYTES):0]     in_nbytes,
  input  logic                            check_en,
  input  logic [31:0]                     crc_exp,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [31:0]                     res_crc,
  output logic                            res_ok,
  output logic [LEN_W-1:0]                res_len,
  output logic                            proto_err
);

  localparam int NB_W = $clog2(DATA_BYTES) + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       crc_reg;
  logic [LEN_W-1:0]  len_reg;

  logic              accept;
  logic              start;
  logic              fold;
  logic              err_next;
  logic              nbytes_bad;
  logic [NB_W-1:0]   n_eff;
  logic [31:0]       crc_base;
  logic [31:0]       crc_end;
  logic [LEN_W-1:0]  len_base;
  logic [LEN_W:0]    len_wide;
  logic [LEN_W-1:0]  len_sum;

  // One byte of the reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Stall only while an unconsumed result would be overwritten.
  assign in_ready = !(res_valid && !res_ready);
  assign accept   = in_valid && in_ready;

  // Out-of-range byte counts on eop fall back to a full beat.
  assign nbytes_bad = (in_nbytes == '0) || (in_nbytes > NB_W'(DATA_BYTES));
  assign n_eff      = (in_eop && !nbytes_bad) ? in_nbytes : NB_W'(DATA_BYTES);

  // A new sop always restarts from SEED, even if a packet was in flight.
  assign crc_base = start ? SEED : crc_reg;
  assign len_base = start ? '0 : len_reg;

  // Single-cycle fold of the valid low bytes: a chain of byte stages where
  // stages beyond n_eff pass the CRC through unchanged.
  logic [31:0] crc_chain [DATA_BYTES+1];
  assign crc_chain[0] = crc_base;
  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_fold
      assign crc_chain[gi+1] = (NB_W'(gi) < n_eff) ? crc_byte(crc_chain[gi], in_data[8*gi +: 8])
                                                   : crc_chain[gi];
    end
  endgenerate
  assign crc_end = crc_chain[DATA_BYTES];

  // Saturating length: carry out of LEN_W bits clamps to all ones.
  assign len_wide = {1'b0, len_base} + (LEN_W+1)'(n_eff);
  assign len_sum  = len_wide[LEN_W] ? '1 : len_wide[LEN_W-1:0];

  // Packet-state next-state logic.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    fold       = 1'b0;
    err_next   = 1'b0;
    if (accept) begin
      if (in_sop) begin
        start      = 1'b1;
        fold       = 1'b1;
        err_next   = (state_reg == IN_PKT);
        state_next = in_eop ? IDLE : IN_PKT;
      end else if (state_reg == IDLE) begin
        err_next   = 1'b1;             // orphan beat: dropped
      end else begin
        fold       = 1'b1;
        if (in_eop) state_next = IDLE;
      end
      if (in_eop && nbytes_bad) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      crc_reg   <= SEED;
      len_reg   <= '0;
      res_valid <= 1'b0;
      res_crc   <= '0;
      res_ok    <= 1'b0;
      res_len   <= '0;
      proto_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      proto_err <= err_next;
      if (fold) begin
        crc_reg <= in_eop ? SEED : crc_end;
        len_reg <= in_eop ? '0 : len_sum;
      end
      // A new eop is only accepted when the old result is gone or being
      // consumed this edge, so replacing it here never loses a result.
      if (fold && in_eop) begin
        res_valid <= 1'b1;
        res_crc   <= ~crc_end;
        res_ok    <= check_en ? (~crc_end == crc_exp) : 1'b1;
        res_len   <= len_sum;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pcie_lcrc_stream.md
Name: pcie_lcrc_stream

Overview:
Streaming, parametrised LCRC generator/checker for the PCIe data link layer. It accepts a TLP (sequence-number prefix plus TLP bytes) as a valid/ready beat stream of DATA_BYTES bytes per beat with a byte count on the last beat. It returns a registered 32-bit LCRC per packet, plus a pass/fail flag when checking a received LCRC. It sits between the DLL TX framer and the PHY, and mirrored on the RX path.

Parameters:
DATA_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8, 16.
LEN_W, 16, width of the packet byte counter.
SEED, 32'hFFFF_FFFF, CRC register initial value.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_sop  in  1  first beat of packet
in_eop  in  1  last beat of packet
in_data  in  8*DATA_BYTES  byte k = in_data[8k+7:8k]; byte 0 is first on the wire
in_nbytes  in  $clog2(DATA_BYTES)+1  valid bytes on eop beat (1..DATA_BYTES; low bytes valid); ignored when !in_eop
check_en  in  1  sampled on eop beat; 1 = compare against crc_exp
crc_exp  in  32  received LCRC, sampled on eop beat
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid && res_ready
res_crc  out  32  final LCRC; res_crc[7:0] is transmitted first
res_ok  out  1  check_en ? (res_crc == crc_exp) : 1
res_len  out  LEN_W  packet byte count, saturating
proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, rst_n=0): crc_reg=SEED, in_pkt=0, len=0, res_valid=0, res_crc=0, res_ok=0, res_len=0, proto_err=0. in_ready is combinational and therefore 1.
- Algorithm: CRC-32, poly 0x04C11DB7, reflected (each byte processed bit 0 first), init SEED, final XOR 0xFFFFFFFF. No byte swap on output. Check value over ASCII "123456789" = 0xCBF43926.
- Per accepted beat, bytes 0..n-1 are folded into crc_reg in order. n = DATA_BYTES, or in_nbytes on eop. A single-cycle combinational fold of all bytes is used; no multicycle path.
- in_ready = !(res_valid && !res_ready). Stalls only while an unconsumed result is pending.
- Packet state, two states:
  - IDLE: a beat with in_sop starts a packet, folding from SEED and setting len=n. A beat without in_sop is dropped and pulses proto_err.
  - IN_PKT: beats fold and len += n, saturating at 2^LEN_W-1.
  - eop moves to IDLE, including an sop&&eop single-beat packet.
- sop while IN_PKT: the partial packet is discarded without a result, the new packet restarts from SEED, and proto_err pulses.
- Result latency: the eop beat is accepted at cycle t; at t+1 res_valid=1 with res_crc = ~crc_final, res_len, and res_ok. Outputs hold until the handshake.
- Back-to-back packets with res_ready=1 give one result per eop, with no bubble on the input.
- Simultaneous res handshake and new eop acceptance: res_valid stays 1 and the new result replaces the old in the same edge.
- in_nbytes=0 or >DATA_BYTES on eop: treated as DATA_BYTES, and proto_err pulses.
- proto_err rises the cycle after the offending beat and is a single-cycle pulse.
- res_ok compares the full 32 bits.
- Reset mid-packet: all state returns to reset values immediately; a pending result is lost.

Test Plan:
- DATA_BYTES=1, "123456789" as 9 beats (sop on first, eop on last with in_nbytes=1) -> res_crc=0xCBF43926, res_len=9, res_ok=1.
- DATA_BYTES=4, "123456789" as 3 beats with last in_nbytes=1 -> res_crc=0xCBF43926, result one cycle after eop. Repeat with a single 0x00 byte -> 0xD202EF8D; four 0x00 bytes -> 0x2144DF1C.
- Check mode, DATA_BYTES=4, "123456789" with check_en=1:
  - crc_exp=0xCBF43926 -> res_ok=1.
  - crc_exp=0xCBF43927 -> res_ok=0.
- Backpressure: two back-to-back 1-beat packets with res_ready=0 -> in_ready drops after the first result. The second eop waits; after one res_ready pulse, the second result appears on the next cycle.
- Protocol errors:
  - Beat without sop in IDLE -> proto_err pulse, no result.
  - sop mid-packet -> proto_err pulse; the result equals the CRC of the restarted packet only.
- Assert rst_n low mid-packet, then send "123456789" -> res_valid=0 during reset, then 0xCBF43926 with no contamination from before the reset.
